piso_serializer: RTL
====================

# piso_serializer

Parametrised parallel-in/serial-out serializer that generalises the 8-bit load/shift register to any `WIDTH`. It adds a valid/ready load handshake, a bit-rate strobe, a frame bit counter, MSB/LSB order latched per frame, and gapless back-to-back frames. It sits between a parallel data producer and a serial line driver (SPI-like or UART-like TX datapath).

## Interface

Parameters:
- `WIDTH`, default 8: frame width in bits. Must be ≥ 2.
- `IDLE_LEVEL`, default 1'b0: value driven on `ser_out` when no frame is active.

Ports:
- `clk_in`, in, 1: the only clock. All state updates on its rising edge.
- `rst_n_in`, in, 1: reset, synchronous, active-low. Dominates all other inputs.
- `par_in`, in, WIDTH: frame data, sampled on an accepted load.
- `msb_first_in`, in, 1: bit order, sampled on an accepted load. 1 = MSB first.
- `par_valid_in`, in, 1: producer offers `par_in` / `msb_first_in`.
- `par_ready_out`, out, 1: the serializer can accept a load this cycle.
- `shift_en_in`, in, 1: bit-rate strobe. Each strobe in SHIFT advances one bit.
- `ser_in`, in, 1: fill bit shifted into the vacated end of the register (allows chaining).
- `ser_out`, out, 1: serial data.
- `ser_valid_out`, out, 1: high while `ser_out` carries a frame bit.
- `latched_msb_out`, out, 1: bit order of the current or last frame.
- `busy_out`, out, 1: high in SHIFT.
- `frame_done_out`, out, 1: one-cycle pulse after the last bit of a frame.

## Operation

- State machine has two states: IDLE and SHIFT.
- Registers:
  - `shift_reg` [WIDTH].
  - `bits_left` [$clog2(WIDTH+1)].
  - `latched_msb`.
  - `frame_done` (registered).
- Accept: a load is accepted when `par_valid_in && par_ready_out`.
- `par_ready_out` (combinational):
  - high in IDLE;
  - high in SHIFT when `bits_left == 1 && shift_en_in`, which gives the back-to-back path;
  - low otherwise.
- Producer rule: the producer holds `par_in` / `msb_first_in` stable while valid and not ready.
- On accept: `shift_reg <= par_in`, `latched_msb <= msb_first_in`, `bits_left <= WIDTH`, state <= SHIFT.
- In SHIFT with `shift_en_in = 1` and `bits_left > 1`:
  - MSB mode: `shift_reg <= {shift_reg[WIDTH-2:0], ser_in}`.
  - LSB mode: `shift_reg <= {ser_in, shift_reg[WIDTH-1:1]}`.
  - `bits_left` decrements.
- In SHIFT with `shift_en_in = 1` and `bits_left == 1` (last bit consumed):
  - `frame_done <= 1`.
  - If a load is accepted on the same edge, the new frame loads and the state stays SHIFT.
  - Otherwise the state goes to IDLE.
- In SHIFT with `shift_en_in = 0`: hold all registers.
- In IDLE: `shift_en_in` and `ser_in` are ignored, and `shift_reg` holds.
- `frame_done` is high for exactly one cycle after the final strobe, and low otherwise.
- `ser_out`:
  - in SHIFT: `latched_msb ? shift_reg[WIDTH-1] : shift_reg[0]`;
  - in IDLE: `IDLE_LEVEL`.
- `ser_valid_out` and `busy_out` equal (state == SHIFT).
- `latched_msb_out` equals `latched_msb`. It persists through IDLE.

## Timing

- Reset values (edge with `rst_n_in = 0`):
  - state IDLE, `shift_reg` 0, `bits_left` 0, `latched_msb` 0, `frame_done` 0.
  - Hence `ser_out = IDLE_LEVEL`, `ser_valid_out` 0, `busy_out` 0, `frame_done_out` 0, `par_ready_out` 1 once reset is released.
- Reset mid-frame aborts the frame immediately: no `frame_done_out` pulse and no partial bits afterwards.
- Load accepted at edge E:
  - bit 0 of the frame appears on `ser_out` after E, with zero additional latency;
  - bit i appears after the i-th subsequent strobe.
- With `shift_en_in` tied high:
  - bit i is driven in the cycle following edge E+i, for i = 0..WIDTH-1;
  - `frame_done_out` is high in the cycle following edge E+WIDTH;
  - a back-to-back load accepted at E+WIDTH gives a gapless stream (WIDTH bits per WIDTH cycles).
- `par_valid_in` asserted mid-frame (before the last strobe) is not accepted and has no effect.
- `par_ready_out` depends combinationally on `shift_en_in`. The producer must not make `par_valid_in` depend on `par_ready_out`.

## Test plan

- Reset, then MSB-first load, WIDTH=8, `shift_en_in` = 1:
  - stimulus: load `par_in` = 0xA5, `msb_first_in` = 1;
  - `ser_out` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles, `ser_valid_out` high for exactly 8 cycles;
  - `frame_done_out` pulses once, then `ser_out = IDLE_LEVEL`.
- LSB-first load:
  - stimulus: load 0xA5 with `msb_first_in` = 0;
  - `ser_out` = 1,0,1,0,0,1,0,1 (LSB order) and `latched_msb_out` = 0;
  - repeat with 0x0F: `ser_out` = 1,1,1,1,0,0,0,0.
- Strobe every 3rd cycle:
  - stimulus: load 0x81 MSB-first with `shift_en_in` high one cycle in three;
  - each bit holds for 3 cycles, and `busy_out` lasts 8 strobes;
  - `par_ready_out` stays low until the last-bit strobe.
- Back-to-back:
  - stimulus: `par_valid_in` held high with 0xFF (MSB-first) then 0x00 (LSB-first);
  - 16 contiguous valid bits, 8 ones then 8 zeros;
  - `frame_done_out` pulses after each frame, and `latched_msb_out` changes only at the frame boundary.
- Mid-frame events:
  - `par_valid_in` pulsed at bit 3 is ignored, and the frame completes unchanged;
  - `rst_n_in` low at bit 4 forces IDLE on the next edge with no `frame_done_out` pulse.
- Chaining with WIDTH=4, MSB-first:
  - stimulus: load 0x0 while `ser_in` = 1;
  - register contents after 4 strobes equal 0xF;
  - a re-check with WIDTH=2 confirms parameter scaling.

Source files
------------

// File: rtl/piso_serializer.sv
// Parametrised parallel-in/serial-out serializer with valid/ready load, bit-rate strobe,
// per-frame bit order and gapless back-to-back frames.
module piso_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] par_in,
    input  logic             msb_first_in,
    input  logic             par_valid_in,
    output logic             par_ready_out,
    input  logic             shift_en_in,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             ser_valid_out,
    output logic             latched_msb_out,
    output logic             busy_out,
    output logic             frame_done_out
);

    localparam int unsigned     CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(WIDTH);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]  bits_left_q, bits_left_d;
    logic             latched_msb_q, latched_msb_d;
    logic             frame_done_q, frame_done_d;
    logic             last_strobe;
    logic             accept;

    // Readiness on the final strobe lets the next frame load with no idle gap.
    assign last_strobe   = (state_q == StShift) && shift_en_in && (bits_left_q == CntOne);
    assign par_ready_out = (state_q == StIdle) || last_strobe;
    assign accept        = par_valid_in && par_ready_out;

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bits_left_d   = bits_left_q;
        latched_msb_d = latched_msb_q;
        frame_done_d  = 1'b0;

        if ((state_q == StShift) && shift_en_in) begin
            shift_d     = latched_msb_q ? {shift_q[WIDTH-2:0], ser_in}
                                        : {ser_in, shift_q[WIDTH-1:1]};
            bits_left_d = bits_left_q - CntOne;
            if (last_strobe) begin
                frame_done_d = 1'b1;
                state_d      = StIdle;
            end
        end

        // A same-edge load overrides the final shift and keeps the frame stream going.
        if (accept) begin
            shift_d       = par_in;
            latched_msb_d = msb_first_in;
            bits_left_d   = CntFull;
            state_d       = StShift;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q       <= StIdle;
            shift_q       <= '0;
            bits_left_q   <= '0;
            latched_msb_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bits_left_q   <= bits_left_d;
            latched_msb_q <= latched_msb_d;
            frame_done_q  <= frame_done_d;
        end
    end

    always_comb begin
        ser_out = IDLE_LEVEL;
        if (state_q == StShift) begin
            ser_out = latched_msb_q ? shift_q[WIDTH-1] : shift_q[0];
        end
    end

    assign ser_valid_out   = (state_q == StShift);
    assign busy_out        = (state_q == StShift);
    assign latched_msb_out = latched_msb_q;
    assign frame_done_out  = frame_done_q;

endmodule
